// File: rtl/rbm_hidden_sampler_if.sv
// Bus between the hidden-unit sampler and its controller / probability store.
// The slave side is the sampler; the master side issues passes and serves p_rdata.
interface rbm_hidden_sampler_if #(
  parameter int H_DIM = 64
);
  localparam int AW = $clog2(H_DIM);
  localparam int CW = $clog2(H_DIM + 1);

  logic              start;
  logic              sample_en;
  logic              seed_load;
  logic [31:0]       seed_val;
  logic              busy;
  logic              done;
  logic              p_rd_en;
  logic [AW-1:0]     p_addr;
  logic [15:0]       p_rdata;
  logic [H_DIM-1:0]  h_vec;
  logic [CW-1:0]     h_count;

  modport slave (
    input  start, sample_en, seed_load, seed_val, p_rdata,
    output busy, done, p_rd_en, p_addr, h_vec, h_count
  );

  modport master (
    output start, sample_en, seed_load, seed_val, p_rdata,
    input  busy, done, p_rd_en, p_addr, h_vec, h_count
  );
endinterface

// File: rtl/rbm_hidden_sampler.sv
// Bernoulli sampler for RBM hidden units: streams p[j] from a 1-cycle read port,
// draws h[j] against a 32-bit Galois LFSR (or thresholds at 0.5) and counts ones.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; seed_load honoured here only
//   S_RUN   | issuing p_addr 0..H_DIM-1, one per clock
//   S_DRAIN | last read in flight, final sample lands on exit
//   S_DONE  | done pulse, h_vec/h_count valid, busy drops afterwards
module rbm_hidden_sampler #(
  parameter int          H_DIM = 64,
  parameter logic [31:0] SEED  = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rbm_hidden_sampler_if.slave   io_bus
);
  localparam int          AW       = $clog2(H_DIM);
  localparam int          CW       = $clog2(H_DIM + 1);
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [31:0]       r_lfsr;
  logic              r_mode;
  logic              r_vld;
  logic [AW-1:0]     r_sidx;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [AW-1:0]     r_addr;
  logic [H_DIM-1:0]  r_h_vec;
  logic [CW-1:0]     r_h_count;

  logic [31:0]       w_lfsr_next;
  logic [31:0]       w_seed;
  logic [15:0]       w_rnd;
  logic              w_bit;
  logic              w_last_addr;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);
  assign w_seed      = (io_bus.seed_val == 32'h0) ? 32'h1 : io_bus.seed_val;
  assign w_rnd       = r_lfsr[15:0];
  assign w_bit       = r_mode ? (w_rnd < io_bus.p_rdata) : io_bus.p_rdata[15];
  assign w_last_addr = (r_addr == AW'(H_DIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED_EFF;
      r_mode    <= 1'b0;
      r_vld     <= 1'b0;
      r_sidx    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_h_vec   <= '0;
      r_h_count <= '0;
    end else begin
      r_vld <= r_rd_en;

      // Sample path runs off the read-valid pipe, independent of FSM state.
      if (r_vld) begin
        r_h_vec[r_sidx] <= w_bit;
        r_h_count       <= r_h_count + CW'(w_bit);
        r_sidx          <= r_sidx + AW'(1);
        if (r_mode) r_lfsr <= w_lfsr_next;
      end

      case (r_state)
        S_IDLE: begin
          if (io_bus.seed_load) r_lfsr <= w_seed;
          if (io_bus.start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_mode    <= io_bus.sample_en;
            r_h_vec   <= '0;
            r_h_count <= '0;
            r_sidx    <= '0;
            r_rd_en   <= 1'b1;
            r_addr    <= '0;
          end
        end
        S_RUN: begin
          if (w_last_addr) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_addr  <= r_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.p_rd_en = r_rd_en;
  assign io_bus.p_addr  = r_addr;
  assign io_bus.h_vec   = r_h_vec;
  assign io_bus.h_count = r_h_count;
endmodule

// File: tb/tb_rbm_hidden_sampler.sv
// Bench for rbm_hidden_sampler: table of passes scored against a reference LFSR model,
// plus hand sequences for mid-pass reset and long-run statistics.
module tb_rbm_hidden_sampler;
  localparam int          H    = 64;
  localparam int          CW   = $clog2(H + 1);
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rbm_hidden_sampler_if #(.H_DIM(H)) bus ();
  rbm_hidden_sampler #(.H_DIM(H), .SEED(SEED)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  logic [15:0] p_mem [H];
  always @(posedge clk) if (bus.p_rd_en) bus.p_rdata <= p_mem[bus.p_addr];

  typedef struct {
    logic          mode;
    bit            do_seed;
    logic [31:0]   seed;
    int            pat;
    bit            use_model;
    logic [H-1:0]  exp_h;
    int            exp_cnt;
    int            inject;
  } vec_t;

  typedef struct {
    logic [H-1:0]  h;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  logic [31:0] m_lfsr;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  task automatic set_pattern(input int pat);
    for (int j = 0; j < H; j++) begin
      case (pat)
        0:       p_mem[j] = 16'h0000;
        1:       p_mem[j] = 16'hFFFF;
        2:       p_mem[j] = (j % 2 == 0) ? 16'h8000 : 16'h7FFF;
        3:       p_mem[j] = 16'(j * 1024);
        4:       p_mem[j] = 16'h8000;
        5:       p_mem[j] = 16'h4000;
        default: p_mem[j] = 16'($urandom);
      endcase
    end
  endtask

  task automatic model_pass(input logic mode, output logic [H-1:0] h, output int cnt);
    logic b;
    h = '0;
    cnt = 0;
    for (int j = 0; j < H; j++) begin
      if (mode) begin
        b = (m_lfsr[15:0] < p_mem[j]);
        m_lfsr = lfsr_step(m_lfsr);
      end else begin
        b = (p_mem[j] >= 16'h8000);
      end
      h[j] = b;
      cnt += int'(b);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_pass(input vec_t v, output logic [H-1:0] got_h);
    exp_t          e;
    logic [H-1:0]  mh;
    int            mc;
    int            got;
    bit            addr_ok;
    bit            busy_ok;
    set_pattern(v.pat);
    bus.sample_en = v.mode;
    bus.start     = 1'b1;
    if (v.do_seed) begin
      bus.seed_load = 1'b1;
      bus.seed_val  = v.seed;
      m_lfsr = (v.seed == 32'h0) ? 32'h1 : v.seed;
    end
    model_pass(v.mode, mh, mc);
    if (v.use_model) begin
      e.h = mh; e.cnt = CW'(mc);
    end else begin
      e.h = v.exp_h; e.cnt = CW'(v.exp_cnt);
    end
    sb.push_back(e);
    @(posedge clk);
    got = -1;
    addr_ok = 1'b1;
    busy_ok = 1'b1;
    for (int c = 0; c < H + 8; c++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      if (c < H && !(bus.p_rd_en === 1'b1 && bus.p_addr == c)) addr_ok = 1'b0;
      if (c >= H && bus.p_rd_en !== 1'b0) addr_ok = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        got = c;
        break;
      end
      if (c == 10 && v.inject == 1) bus.start = 1'b1;
      if (c == 10 && v.inject == 2) begin
        bus.seed_load = 1'b1;
        bus.seed_val  = 32'h1234_5678;
      end
    end
    check("done_latency", got, H + 1);
    check("addr_seq", addr_ok, 1);
    check("busy_during_pass", busy_ok, 1);
    e = sb.pop_front();
    check("h_vec", bus.h_vec, e.h);
    check("h_count", bus.h_count, e.cnt);
    got_h = bus.h_vec;
    @(negedge clk);
    check("busy_done_low_after", {bus.busy, bus.done}, 0);
    @(negedge clk);
    check("h_vec_hold", bus.h_vec, e.h);
  endtask

  initial begin
    logic [H-1:0] h;
    logic [H-1:0] h_rep;
    vec_t         vs;
    int           ones;

    vecs[0]  = '{1'b0, 0, 32'h0,         2, 0, 64'h5555_5555_5555_5555, 32, 0};
    vecs[1]  = '{1'b0, 0, 32'h0,         3, 0, 64'hFFFF_FFFF_0000_0000, 32, 0};
    vecs[2]  = '{1'b0, 0, 32'h0,         1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0};
    vecs[3]  = '{1'b1, 1, 32'h1,         0, 0, 64'h0,                    0, 0};
    vecs[4]  = '{1'b1, 0, 32'h0,         1, 1, 64'h0,                    0, 0};
    vecs[5]  = '{1'b1, 1, 32'hDEAD_BEEF, 4, 1, 64'h0,                    0, 0};
    vecs[6]  = '{1'b1, 1, 32'hDEAD_BEEF, 4, 1, 64'h0,                    0, 0};
    vecs[7]  = '{1'b1, 0, 32'h0,         4, 1, 64'h0,                    0, 0};
    vecs[8]  = '{1'b1, 0, 32'h0,         6, 1, 64'h0,                    0, 1};
    vecs[9]  = '{1'b0, 0, 32'h0,         0, 0, 64'h0,                    0, 2};
    vecs[10] = '{1'b1, 0, 32'h0,         1, 1, 64'h0,                    0, 0};
    vecs[11] = '{1'b1, 1, 32'h0,         1, 1, 64'h0,                    0, 0};
    vecs[12] = '{1'b0, 0, 32'h0,         6, 1, 64'h0,                    0, 0};

    bus.start     = 1'b0;
    bus.sample_en = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_val  = 32'h0;
    rst_n         = 1'b0;
    h_rep         = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_p_rd_en", bus.p_rd_en, 0);
    check("rst_p_addr",  bus.p_addr, 0);
    check("rst_h_vec",   bus.h_vec, 0);
    check("rst_h_count", bus.h_count, 0);
    rst_n  = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_pass(vecs[i], h);
      if (i == 5) h_rep = h;
      if (i == 6) check("reseed_repro", h, h_rep);
    end

    // Abort a stochastic pass with reset at element 20.
    set_pattern(1);
    bus.sample_en = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy",    bus.busy, 0);
    check("abort_done",    bus.done, 0);
    check("abort_h_vec",   bus.h_vec, 0);
    check("abort_p_rd_en", bus.p_rd_en, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
    vs = '{1'b1, 0, 32'h0, 4, 1, 64'h0, 0, 0};
    run_pass(vs, h);

    ones = 0;
    for (int k = 0; k < 64; k++) begin
      run_pass(vs, h);
      ones += $countones(h);
    end
    check("stat_half_in_range", (ones * 100 >= 47 * 4096) && (ones * 100 <= 53 * 4096), 1);

    vs.pat = 5;
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      run_pass(vs, h);
      ones += $countones(h);
    end
    check("stat_quarter_in_range", (ones * 100 >= 22 * 4096) && (ones * 100 <= 28 * 4096), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
